// File: rtl/lcd_arbiter_if.sv
// Requester-side post/status bus plus the LCDCON transmitter handshake shared by lcd_arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus transmitter side.
interface lcd_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DIGIT = 8,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]         REQ_WE;
  logic [NREQ*DIGIT*4-1:0] REQ_DATA;
  logic [NREQ-1:0]         REQ_PEND;
  logic [NREQ-1:0]         REQ_DONE;
  logic [DIGIT*4-1:0]      LCD_DATA;
  logic                    LCD_WE;
  logic                    LCD_READY;
  logic [IDW-1:0]          LCD_ID;
  logic                    BUSY;

  modport master (
    input  REQ_WE, REQ_DATA, LCD_READY,
    output REQ_PEND, REQ_DONE, LCD_DATA, LCD_WE, LCD_ID, BUSY
  );

  modport slave (
    output REQ_WE, REQ_DATA, LCD_READY,
    input  REQ_PEND, REQ_DONE, LCD_DATA, LCD_WE, LCD_ID, BUSY
  );
endinterface

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter sharing one LCDCON hex-digit transmitter between NREQ requesters.
// state  | meaning
// IDLE   | waiting for a pending value and LCD_READY; grants and strobes LCD_WE
// ISSUE  | strobe sent; waits for READY to drop, or 4 cycles of READY high
// XMIT   | transmitter busy; on READY high pulses REQ_DONE for LCD_ID
module lcd_arbiter #(
  parameter int NREQ  = 4,
  parameter int DIGIT = 8,
  parameter int IDW   = 2
) (
  input logic          CLK,
  input logic          RST_X,
  lcd_arbiter_if.master bus
);

  localparam int DW = DIGIT * 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_XMIT  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [NREQ-1:0][DW-1:0]  hold_q, hold_d;
  logic [NREQ-1:0]          pend_q, pend_d;
  logic [NREQ-1:0]          done_q, done_d;
  logic [IDW-1:0]           rr_q, rr_d;
  logic [IDW-1:0]           id_q, id_d;
  logic [DW-1:0]            data_q, data_d;
  logic                     we_q, we_d;
  logic [1:0]               wcnt_q, wcnt_d;

  logic                     gnt_vld;
  logic [IDW-1:0]           gnt_idx;
  logic [IDW-1:0]           gnt_next;

  // Scan from the top offset down so the nearest pending slot after rr wins.
  always_comb begin : grant_search
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (pend_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[IDW-1:0];
      end
    end
    gnt_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_comb begin : next_state
    state_d = state_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    done_d  = '0;
    rr_d    = rr_q;
    id_d    = id_q;
    data_d  = data_q;
    we_d    = 1'b0;
    wcnt_d  = wcnt_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_vld && bus.LCD_READY) begin
          data_d          = hold_q[gnt_idx];
          we_d            = 1'b1;
          id_d            = gnt_idx;
          pend_d[gnt_idx] = 1'b0;
          rr_d            = gnt_next;
          wcnt_d          = 2'd3;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.LCD_READY || wcnt_q == 2'd0) state_d = S_XMIT;
        else                                  wcnt_d  = wcnt_q - 2'd1;
      end
      S_XMIT: begin
        if (bus.LCD_READY) begin
          for (int i = 0; i < NREQ; i++)
            if (id_q == IDW'(i)) done_d[i] = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A post in the grant cycle re-arms pend after the grant has used the old value.
    for (int i = 0; i < NREQ; i++) begin
      if (bus.REQ_WE[i]) begin
        hold_d[i] = bus.REQ_DATA[i*DW +: DW];
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      pend_q  <= '0;
      done_q  <= '0;
      rr_q    <= '0;
      id_q    <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      we_q    <= we_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.REQ_PEND = pend_q;
  assign bus.REQ_DONE = done_q;
  assign bus.LCD_DATA = data_q;
  assign bus.LCD_WE   = we_q;
  assign bus.LCD_ID   = id_q;
  assign bus.BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_lcd_arbiter.sv
// Directed bench for lcd_arbiter: scoreboard of expected (id, data) issues plus a simple transmitter model.
module tb_lcd_arbiter;
  localparam int NREQ = 4, DIGIT = 8, IDW = 2, XLEN = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_low = 1'b0;
  int   busy_cnt;
  int   checks = 0, failures = 0, n_issue = 0;
  int   done_cnt[NREQ];
  int   base[NREQ];
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_arbiter_if #(.NREQ(NREQ), .DIGIT(DIGIT), .IDW(IDW)) bus ();

  lcd_arbiter #(.NREQ(NREQ), .DIGIT(DIGIT), .IDW(IDW)) dut (
    .CLK   (clk),
    .RST_X (rst_n),
    .bus   (bus)
  );

  // Transmitter model: READY drops the cycle after WE and stays low XLEN cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          busy_cnt <= 0;
    else if (bus.LCD_WE) busy_cnt <= XLEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.LCD_READY = (busy_cnt == 0) && !force_low;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;

  always @(negedge clk) begin
    if (bus.LCD_WE === 1'b1) begin
      n_issue++;
      check("sb_expected_issue", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("sb_lcd_id", 64'(bus.LCD_ID), 64'(e[33:32]));
        check("sb_lcd_data", 64'(bus.LCD_DATA), 64'(e[31:0]));
      end
    end
    if (bus.REQ_DONE !== '0) begin
      check("done_onehot", 64'(bus.REQ_DONE), 64'(1) << bus.LCD_ID);
      for (int i = 0; i < NREQ; i++) if (bus.REQ_DONE[i] === 1'b1) done_cnt[i]++;
    end
  end

  task automatic drive(input logic [NREQ-1:0] we, input logic [NREQ*32-1:0] data);
    bus.REQ_WE   = we;
    bus.REQ_DATA = data;
    @(negedge clk);
    bus.REQ_WE   = '0;
  endtask

  task automatic snap();
    for (int i = 0; i < NREQ; i++) base[i] = done_cnt[i];
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(bus.BUSY === 1'b0 && bus.REQ_PEND === '0 && bus.LCD_READY === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 64'(n < budget), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_xmit(input string tag);
    int n = 0;
    while (!(bus.BUSY === 1'b1 && bus.LCD_READY === 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_xmit_timeout"}, 64'(n < 50), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},   64'(bus.LCD_WE),   64'd0);
    check({tag, "_data"}, 64'(bus.LCD_DATA), 64'd0);
    check({tag, "_id"},   64'(bus.LCD_ID),   64'd0);
    check({tag, "_pend"}, 64'(bus.REQ_PEND), 64'd0);
    check({tag, "_done"}, 64'(bus.REQ_DONE), 64'd0);
    check({tag, "_busy"}, 64'(bus.BUSY),     64'd0);
  endtask

  initial begin
    int n0;
    bus.REQ_WE   = '0;
    bus.REQ_DATA = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: pend at t+1, LCD_WE at t+2
    snap();
    exp_q.push_back({2'd1, 32'h1234abcd});
    drive(4'b0010, {4{32'h1234abcd}});
    check("single_pend", 64'(bus.REQ_PEND), 64'b0010);
    check("single_we_not_yet", 64'(bus.LCD_WE), 64'd0);
    @(negedge clk);
    check("single_we_t2", 64'(bus.LCD_WE), 64'd1);
    wait_idle(100, "single");
    check("single_done1", 64'(done_cnt[1] - base[1]), 64'd1);

    // Fairness from rr=0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    snap();
    for (int i = 0; i < NREQ; i++) exp_q.push_back({2'(i), {8{4'(i)}}});
    drive(4'b1111, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
    wait_idle(400, "fair4");
    for (int i = 0; i < NREQ; i++) check($sformatf("fair4_done%0d", i), 64'(done_cnt[i] - base[i]), 64'd1);

    snap();
    exp_q.push_back({2'd0, 32'ha0a0a0a0});
    exp_q.push_back({2'd2, 32'hc2c2c2c2});
    drive(4'b0101, {32'h0, 32'hc2c2c2c2, 32'h0, 32'ha0a0a0a0});
    wait_idle(200, "fair2");
    check("fair2_done0", 64'(done_cnt[0] - base[0]), 64'd1);
    check("fair2_done2", 64'(done_cnt[2] - base[2]), 64'd1);

    // Overwrite while requester 0 transmits
    snap();
    exp_q.push_back({2'd0, 32'h0f0f0f0f});
    exp_q.push_back({2'd3, 32'h55555555});
    drive(4'b0001, {96'h0, 32'h0f0f0f0f});
    wait_xmit("ovw");
    drive(4'b1000, {32'haaaaaaaa, 96'h0});
    drive(4'b1000, {32'h55555555, 96'h0});
    check("ovw_pend3", 64'(bus.REQ_PEND), 64'b1000);
    wait_idle(200, "ovw");
    check("ovw_done3", 64'(done_cnt[3] - base[3]), 64'd1);
    check("ovw_done0", 64'(done_cnt[0] - base[0]), 64'd1);

    // Self-repost in the grant cycle
    snap();
    exp_q.push_back({2'd2, 32'h600df00d});
    exp_q.push_back({2'd2, 32'hbeef0002});
    drive(4'b0100, {32'h0, 32'h600df00d, 64'h0});
    bus.REQ_WE   = 4'b0100;
    bus.REQ_DATA = {32'h0, 32'hbeef0002, 64'h0};
    @(negedge clk);
    bus.REQ_WE = '0;
    check("self_we", 64'(bus.LCD_WE), 64'd1);
    check("self_pend2", 64'(bus.REQ_PEND[2]), 64'd1);
    wait_idle(200, "self");
    check("self_done2", 64'(done_cnt[2] - base[2]), 64'd2);

    // READY held low externally
    force_low = 1'b1;
    exp_q.push_back({2'd1, 32'h0badcafe});
    drive(4'b0010, {64'h0, 32'h0badcafe, 32'h0});
    n0 = n_issue;
    repeat (6) @(negedge clk);
    check("rdylow_no_issue", 64'(n_issue - n0), 64'd0);
    check("rdylow_pend1", 64'(bus.REQ_PEND), 64'b0010);
    check("rdylow_busy", 64'(bus.BUSY), 64'd0);
    force_low = 1'b0;
    @(negedge clk);
    check("rdylow_we_after_rise", 64'(bus.LCD_WE), 64'd1);
    wait_idle(200, "rdylow");

    // Asynchronous reset mid-transmission
    exp_q.push_back({2'd0, 32'h77777777});
    drive(4'b0001, {96'h0, 32'h77777777});
    wait_xmit("mrst");
    drive(4'b1000, {32'h33333333, 96'h0});
    check("mrst_pend3", 64'(bus.REQ_PEND[3]), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = n_issue;
    repeat (20) @(negedge clk);
    check("mrst_no_issue", 64'(n_issue - n0), 64'd0);
    check("mrst_we_low", 64'(bus.LCD_WE), 64'd0);
    check("mrst_busy", 64'(bus.BUSY), 64'd0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule
